// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: multi-cycle multiply, radix-2 restoring divide,
// valid/ready request handshake with destination tag and a flush (kill) input.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_o,
    output logic [4:0]      res_rd_addr_o
);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, rem_q;
    logic              neg_q, neg_r;
    logic [4:0]        rd_q;
    logic              accept, emit, div_fast, div_signed;
    logic [XLEN-1:0]   emit_val, fast_val;
    logic [4:0]        emit_rd;

    // Full 2*XLEN product from sign-extended operands; high or low half selected by op.
    function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic signed [2*XLEN-1:0] sa, sb, p;
        sa = {{XLEN{((op == 3'd1) || (op == 3'd2)) & a[XLEN-1]}}, a};
        sb = {{XLEN{(op == 3'd1) & b[XLEN-1]}}, b};
        p  = sa * sb;
        return (op == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    // One restoring step; returns {remainder, quotient}. rem < divisor keeps diff in XLEN+1 bits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0] sh, diff;
        sh   = {rem, quo[XLEN-1]};
        diff = sh - {1'b0, dvs};
        if (!diff[XLEN])
            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] fix_result(input logic is_rem, input logic nq, input logic nr,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] rem);
        if (is_rem)
            return nr ? -rem : rem;
        return nq ? -quo : quo;
    endfunction

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o && !kill_i;
    assign div_signed  = !op_i[0];

    always_comb begin
        div_fast = 1'b0;
        fast_val = '0;
        if (rs2_i == '0) begin
            div_fast = 1'b1;
            fast_val = op_i[1] ? rs1_i : '1;
        end else if (div_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1)) begin
            div_fast = 1'b1;
            fast_val = op_i[1] ? '0 : rs1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        emit     = 1'b0;
        emit_val = '0;
        emit_rd  = rd_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    emit_rd = rd_addr_i;
                    if (!op_i[2]) begin
                        if (MUL_LAT == 1) begin
                            emit     = 1'b1;
                            emit_val = mul_result(op_i, rs1_i, rs2_i);
                        end else begin
                            state_n = MUL;
                            cnt_n   = CNT_W'(MUL_LAT - 1);
                        end
                    end else if (div_fast) begin
                        emit     = 1'b1;
                        emit_val = fast_val;
                    end else begin
                        state_n = DIV;
                        cnt_n   = CNT_W'(XLEN);
                    end
                end
            end
            MUL: begin
                if (kill_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    emit     = 1'b1;
                    emit_val = mul_result(op_q, a_q, b_q);
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DIV: begin
                if (kill_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_n = FIX;
                end
            end
            FIX: begin
                state_n = IDLE;
                if (!kill_i) begin
                    emit     = 1'b1;
                    emit_val = fix_result(op_q[1], neg_q, neg_r, a_q, rem_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o   <= 1'b0;
            res_o         <= '0;
            res_rd_addr_o <= '0;
        end else begin
            res_valid_o <= emit;
            if (emit) begin
                res_o         <= emit_val;
                res_rd_addr_o <= emit_rd;
            end
        end
    end

    // Operand/datapath registers carry no reset; they are only observed through emit.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q <= op_i;
            rd_q <= rd_addr_i;
            if (op_i[2]) begin
                a_q   <= magnitude(rs1_i, div_signed);
                b_q   <= magnitude(rs2_i, div_signed);
                rem_q <= '0;
                neg_q <= div_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                neg_r <= div_signed & rs1_i[XLEN-1];
            end else begin
                a_q <= rs1_i;
                b_q <= rs2_i;
            end
        end else if (state == DIV) begin
            {rem_q, a_q} <= div_step(rem_q, a_q, b_q);
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and reference-model checks for muldiv_unit at XLEN=32, MUL_LAT=2.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, kill, res_valid;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, res;
    logic [4:0]  rd_addr, res_rd_addr;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd = '0;

    muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_addr_i(rd_addr), .kill_i(kill),
        .res_valid_o(res_valid), .res_o(res), .res_rd_addr_o(res_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; sp = sa / sb; return sp[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return 2;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    // Issue one request, wait (bounded) for its result, check latency/value/tag/single pulse.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        check({tag, " ready"}, req_ready, 1);
        req_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd_addr = rd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " value"}, res, exp);
        check({tag, " tag"}, res_rd_addr, rd);
        last_exp = exp;
        last_rd  = rd;
        @(negedge clk);
        check({tag, " pulse"}, res_valid, 0);
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        check({tag, " no result"}, pulses, 0);
    endtask

    initial begin
        int n, accepts;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; req_valid = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset ready", req_ready, 0);
        check("reset valid", res_valid, 0);
        check("reset res", res, 0);
        check("reset rd", res_rd_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        check("release ready", req_ready, 1);

        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 2);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 2);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 2);
        run_op("mul",    3'd0, 32'd3, 32'd4, 5'd4, 32'h0000000C, 2);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34);
        run_op("div_nb", 3'd4, 32'd7, 32'hFFFFFFFE, 5'd7, 32'hFFFFFFFD, 34);
        run_op("rem_nb", 3'd6, 32'd7, 32'hFFFFFFFE, 5'd8, 32'h00000001, 34);
        run_op("divu",   3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34);
        run_op("remu",   3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 34);
        run_op("divu0",  3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, 1);
        run_op("remu0",  3'd7, 32'd5, 32'd0, 5'd12, 32'd5, 1);
        run_op("div0",   3'd4, 32'hFFFFFFF9, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
        run_op("rem0",   3'd6, 32'hFFFFFFF9, 32'd0, 5'd14, 32'hFFFFFFF9, 1);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1);

        // Kill with a same-cycle request in IDLE: nothing accepted.
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; op = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd_addr = 5'd20;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        check("kill idle valid", res_valid, 0);
        check("kill idle ready", req_ready, 1);
        count_pulses("kill idle", 3);

        // Kill at cycle 10 of a divide.
        @(negedge clk);
        req_valid = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill div ready", req_ready, 1);
        count_pulses("kill div", 40);
        check("kill div res held", res, last_exp);
        check("kill div rd held", res_rd_addr, last_rd);
        run_op("mul after kill", 3'd0, 32'd3, 32'd4, 5'd22, 32'd12, 2);

        // Reset pulse mid-divide.
        @(negedge clk);
        req_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_addr = 5'd23;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst ready", req_ready, 1);
        check("post rst valid", res_valid, 0);
        check("post rst res", res, 0);
        check("post rst rd", res_rd_addr, 0);
        count_pulses("post rst", 40);

        // Request held during a divide; second request taken in the result cycle.
        @(negedge clk);
        accepts = 0;
        req_valid = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd24;
        if (req_ready) accepts++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!res_valid && req_ready) accepts++;
        end while (!res_valid && n < 100);
        check("held latency", n, 34);
        check("held accepts", accepts, 1);
        check("held value", res, 14);
        check("held tag", res_rd_addr, 24);
        check("held b2b ready", req_ready, 1);
        op = 3'd3; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rd_addr = 5'd25;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b latency", n, 2);
        check("b2b value", res, 32'hFFFFFFFE);
        check("b2b tag", res_rd_addr, 25);

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = '0;
            else if (i % 4 == 1) rb = $urandom_range(1, 15);
            else if (i % 4 == 2) ra = $urandom_range(0, 1000);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 5'(i), ref_model(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
